// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin arbiter that shares one magnitude comparator
// among NREQ requesters. One transaction at a time: grant (IDLE), compare (CMP),
// then hold the response until it is consumed (RESP).
// Optional build macro COMPARE_ARBITER_SIGNED_EN: when defined, gt/lt treat the
// operands as two's-complement signed values. When undefined, the compare is unsigned.
module compare_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*WIDTH-1:0]      req_a,
  input  logic [NREQ*WIDTH-1:0]      req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic                       rsp_gt,
  output logic                       rsp_lt,
  output logic                       rsp_eq,
  output logic                       busy
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_sel;
  logic [IDW-1:0]   r_rsp_id;
  logic             r_rsp_valid;
  logic             r_gt;
  logic             r_lt;
  logic             r_eq;
  logic             r_busy;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic             w_found;
  logic [IDW-1:0]   w_sel;
  logic [IDW:0]     w_sum;
  logic [NREQ-1:0]  w_ready;
  logic [IDW-1:0]   w_next_ptr;

  function automatic logic f_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef COMPARE_ARBITER_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  function automatic logic f_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef COMPARE_ARBITER_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  // Round-robin pick: first valid requester at or after r_rr_ptr, with wrap.
  // The sum is one bit wider than an ID so rr_ptr+k never overflows before the
  // modulo-NREQ fold, which keeps this correct for non-power-of-two NREQ.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NREQ)) begin
        w_sum = w_sum - (IDW+1)'(NREQ);
      end
      if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[IDW-1:0];
      end
    end
  end

  // Grant is combinational in IDLE and forced low while reset is asserted.
  always_comb begin
    w_ready = '0;
    if (rst_n && (r_state == IDLE) && w_found) begin
      w_ready[w_sel] = 1'b1;
    end
  end

  assign w_next_ptr = (r_rsp_id == IDW'(NREQ-1)) ? '0 : r_rsp_id + IDW'(1);

  // Operand capture at the request handshake; data path needs no reset.
  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && w_found) begin
      r_a <= req_a[w_sel*WIDTH +: WIDTH];
      r_b <= req_b[w_sel*WIDTH +: WIDTH];
    end
  end

  // Transaction sequencer with registered response, flags and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_sel       <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
      r_gt        <= 1'b0;
      r_lt        <= 1'b0;
      r_eq        <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_sel   <= w_sel;
            r_busy  <= 1'b1;
            r_state <= CMP;
          end
        end
        CMP: begin
          r_gt        <= f_gt(r_a, r_b);
          r_lt        <= f_lt(r_a, r_b);
          r_eq        <= (r_a == r_b);
          r_rsp_id    <= r_sel;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rr_ptr    <= w_next_ptr;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_gt    = r_gt;
  assign rsp_lt    = r_lt;
  assign rsp_eq    = r_eq;
  assign busy      = r_busy;

endmodule

// File: tb/tb_compare_arbiter.sv
// tb_compare_arbiter: directed bench for compare_arbiter with a transaction-level
// reference model checked every cycle, plus literal expectations per scenario.
module tb_compare_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_gt;
  logic                  rsp_lt;
  logic                  rsp_eq;
  logic                  busy;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];

  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  compare_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
    .rsp_lt    (rsp_lt),
    .rsp_eq    (rsp_eq),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference flags {gt,lt,eq} from plain integer arithmetic.
  function automatic logic [2:0] model_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int ai;
    int bi;
    ai = int'(a);
    bi = int'(b);
`ifdef COMPARE_ARBITER_SIGNED_EN
    if (ai >= 128) ai = ai - 256;
    if (bi >= 128) bi = bi - 256;
`endif
    return {ai > bi, ai < bi, ai == bi};
  endfunction

  // Round-robin choice: first valid index starting at ptr, wrapping; -1 if none.
  function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Model state
  int          cyc = 0;
  bit          pending = 0;
  int          hs_cyc = 0;
  int          m_rr = 0;
  int          m_id = 0;
  logic [2:0]  m_f = 3'b000;
  logic [2:0]  last_f = 3'b000;
  int          rsp_count = 0;
  int          accept_cyc = 0;
  int          first_v_cyc = 0;
  bit          prev_v = 0;
  int          grants [$];
  int          hs_q [$];
  int          got_id = 0;
  logic [2:0]  got_f = 3'b000;

  int          pick;
  logic [NREQ-1:0] exp_ready;
  bit          exp_valid;

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("reset_outputs", {21'd0, req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, busy}, 32'd0);
      pending = 0;
      m_rr    = 0;
      last_f  = 3'b000;
      prev_v  = 0;
    end else begin
      pick      = model_pick(req_valid, m_rr);
      exp_ready = (pending || pick < 0) ? '0 : (NREQ'(1) << pick);
      exp_valid = pending && (cyc >= hs_cyc + 2);
      check("ready_onehot0", ($countones(req_ready) <= 1), 1);
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, pending);
      check("rsp_valid", rsp_valid, exp_valid);
      if (exp_valid) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_flags", {rsp_gt, rsp_lt, rsp_eq}, m_f);
      end else begin
        check("flags_hold", {rsp_gt, rsp_lt, rsp_eq}, last_f);
      end
      if (rsp_valid && !prev_v) first_v_cyc = cyc;
      prev_v = rsp_valid;
      if (exp_valid && rsp_ready) begin
        last_f     = m_f;
        m_rr       = (m_id + 1) % NREQ;
        pending    = 0;
        accept_cyc = cyc;
        got_id     = int'(rsp_id);
        got_f      = {rsp_gt, rsp_lt, rsp_eq};
        rsp_count++;
      end else if (!pending && exp_ready != '0) begin
        pending = 1;
        hs_cyc  = cyc;
        m_id    = pick;
        m_f     = model_flags(op_a[pick], op_b[pick]);
        grants.push_back(pick);
        hs_q.push_back(cyc);
      end
    end
  end

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 60; i++) begin
      if (rsp_count >= target) break;
      @(negedge clk); #1;
    end
    check("rsp_wait", (rsp_count >= target), 1);
  endtask

  task automatic wait_grant(input int nb);
    for (int i = 0; i < 40; i++) begin
      if (hs_q.size() > nb) break;
      @(negedge clk); #1;
    end
    check("grant_wait", (hs_q.size() > nb), 1);
  endtask

  task automatic do_txn(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    int nb;
    n  = rsp_count;
    nb = hs_q.size();
    op_a[idx] = a;
    op_b[idx] = b;
    req_valid[idx] = 1'b1;
    wait_grant(nb);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    wait_rsp(n + 1);
  endtask

  int n0;
  int nb0;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    check("init_rsp_valid", rsp_valid, 0);
    check("init_busy", busy, 0);
    check("init_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;

    // Single request, A > B
    do_txn(0, 8'd200, 8'd17);
    check("t1_id", got_id, 0);
    check("t1_flags", got_f, 3'b100);
    check("t1_latency", first_v_cyc - hs_q[hs_q.size()-1], 2);

    // Equal and less-than
    do_txn(1, 8'h3C, 8'h3C);
    check("eq_id", got_id, 1);
    check("eq_flags", got_f, 3'b001);
    do_txn(2, 8'd5, 8'd9);
    check("lt_id", got_id, 2);
    check("lt_flags", got_f, 3'b010);

    // Round robin from a fresh reset with all requesters held valid
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    grants.delete();
    hs_q.delete();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 8'(10 * (i + 1));
      op_b[i] = 8'd25;
    end
    n0 = rsp_count;
    req_valid = 4'b1111;
    wait_rsp(n0 + 5);
    req_valid = 4'b0000;
    check("rr_g0", grants[0], 0);
    check("rr_g1", grants[1], 1);
    check("rr_g2", grants[2], 2);
    check("rr_g3", grants[3], 3);
    check("rr_g4", grants[4], 0);
    for (int i = 1; i < 5; i++) check("rr_spacing", hs_q[i] - hs_q[i-1], 3);

    // Backpressure on the response, with all requesters pending meanwhile
    @(posedge clk); #1;
    op_a[2]   = 8'd10;
    op_b[2]   = 8'd3;
    rsp_ready = 1'b0;
    nb0       = hs_q.size();
    req_valid = 4'b0100;
    wait_grant(nb0);
    @(posedge clk); #1;
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) break;
      @(negedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, 2);
      check("bp_flags", {rsp_gt, rsp_lt, rsp_eq}, 3'b100);
      check("bp_req_ready", req_ready, 0);
      check("bp_busy", busy, 1);
      if (i < 4) begin
        @(negedge clk); #1;
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    nb0 = hs_q.size();
    wait_grant(nb0);
    check("bp_next_gap", hs_q[hs_q.size()-1] - accept_cyc, 1);
    check("bp_next_id", grants[grants.size()-1], 3);
    n0 = rsp_count;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_rsp(n0 + 1);

    // Move the pointer off zero, then reset during CMP
    do_txn(1, 8'd7, 8'd7);
    nb0 = hs_q.size();
    req_valid = 4'b1111;
    wait_grant(nb0);
    check("pre_reset_grant", grants[grants.size()-1], 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {21'd0, req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, busy}, 32'd0);
    n0 = rsp_count;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nb0 = hs_q.size();
    wait_grant(nb0);
    check("post_reset_ready", req_ready, 4'b0001);
    check("post_reset_no_rsp", rsp_count, n0);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_rsp(n0 + 1);

    // Signed/unsigned decision
    do_txn(0, 8'hFF, 8'h01);
`ifdef COMPARE_ARBITER_SIGNED_EN
    check("sign_flags", got_f, 3'b010);
`else
    check("sign_flags", got_f, 3'b100);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/compare_arbiter.md
Name: compare_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one magnitude comparator (gt/lt/eq over WIDTH-bit operands) among NREQ requesters.
- Each requester presents an operand pair over a valid/ready handshake. The block grants one requester, registers the operands, performs the compare, and returns the flags plus the requester ID over a single response handshake.
- Sits between multiple client engines and the shared comparator datapath.

Parameters:
- WIDTH, 8, operand bit-width (>=1)
- NREQ, 4, number of requesters (>=2)
- IDW (localparam), $clog2(NREQ), requester ID width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; one-hot or zero
- req_a  input  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B, same packing
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  IDW  index of the granted requester
- rsp_gt  output  1  A > B
- rsp_lt  output  1  A < B
- rsp_eq  output  1  A == B
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - rsp_valid, rsp_gt, rsp_lt, rsp_eq = 0; rsp_id = 0; busy = 0.
  - req_ready = 0 while rst_n is low.
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - If req_valid != 0, select the first set bit scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - req_ready[sel] = 1 combinationally in the same cycle; all other bits 0.
  - At the clock edge: latch req_a/req_b slices and sel, go to CMP.
  - If req_valid == 0: stay in IDLE, req_ready = 0.
- CMP:
  - Compute flags from the latched operands and register them into rsp_gt/lt/eq; register rsp_id.
  - Go to RESP. req_ready = 0.
- RESP:
  - rsp_valid = 1; rsp_id and flags hold stable while rsp_ready = 0.
  - On rsp_valid && rsp_ready: rr_ptr = (granted ID + 1) mod NREQ; go to IDLE; rsp_valid falls next cycle.
  - req_ready = 0 throughout.
- Latency and throughput:
  - Request handshake at cycle T gives rsp_valid at T+2.
  - Minimum 3 cycles per transaction (no overlap).
- Flags: exactly one of gt/lt/eq is high whenever rsp_valid = 1; flags hold their last value when rsp_valid = 0.
- Requester rules: must hold req_valid and operands stable until req_ready. Operands are sampled only at the handshake edge; later changes have no effect.
- Simultaneous requests: strict round-robin. A requester that is continuously valid is served within NREQ grants.
- Single requester: the repeatedly valid requester is re-granted every transaction; rr_ptr wraps NREQ-1 -> 0.
- Reset mid-operation: the in-flight transaction is discarded, no response is produced, rr_ptr returns to 0.

Optional Feature:
- Macro: COMPARE_ARBITER_SIGNED_EN
- Defined: operands are two's-complement signed for the gt/lt decision; eq is unchanged.
- Undefined: unsigned compare.
- Ports, timing and arbitration are identical in both builds.

Test Plan:
- Reset then single request: req_valid=4'b0001, a=8'd200, b=8'd17.
  - req_ready=4'b0001 at T; rsp_valid at T+2.
  - Response: rsp_id=0, gt=1, lt=0, eq=0.
- Equal and less-than cases: a=8'h3C, b=8'h3C -> eq=1 only. a=8'd5, b=8'd9 -> lt=1 only.
- Round robin: req_valid=4'b1111 held, rsp_ready=1.
  - Grants 0,1,2,3,0 in order.
  - Each transaction takes 3 cycles; req_ready one-hot or zero every cycle.
- Backpressure: rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid, rsp_id and flags stable; req_ready=0; busy=1.
  - After rsp_ready=1, next grant occurs 1 cycle later.
- Reset mid-op: assert rst_n=0 while in CMP.
  - All outputs return to reset values immediately; no rsp_valid after release.
  - Next grant with req_valid=4'b1111 goes to requester 0.
- COMPARE_ARBITER_SIGNED_EN: a=8'hFF, b=8'h01.
  - Defined: lt=1.
  - Undefined: gt=1.
